fifo_drain_ctrl: RTL and testbench

Read-side drain engine for the async FIFO, running in the read clock domain. It consumes the FIFO's empty flag and the registered memory read port (`rd_inc` → `rd_data`, one-cycle latency) and presents words on a valid/ready stream to the downstream consumer. A 2-entry holding buffer sustains one word per cycle while guaranteeing the memory is never read past empty and no word is lost under backpressure.

---
 rtl/fifo_drain_ctrl.sv | 58 +++++
 tb/tb_fifo_drain_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: read-domain drain engine, FIFO memory port to a 2-deep valid/ready stream.
// Define FIFO_DRAIN_CNT_EN to build the delivered-word counter behind rd_count.
module fifo_drain_ctrl #(
   parameter int DATA_SIZE = 8,
   parameter int CNT_SIZE  = 16
) (
   input  logic                 rd_clk,
   input  logic                 rd_rst,
   input  logic                 rd_empty,
   input  logic [DATA_SIZE-1:0] rd_data,
   output logic                 rd_inc,
   input  logic                 flush,
   output logic [DATA_SIZE-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CNT_SIZE-1:0]  rd_count
);
   logic [1:0]           occ;
   logic                 inflight, head, tail, pop;
   logic [2:0]           level;
   logic [DATA_SIZE-1:0] mem [2];
   assign out_valid = occ != 2'd0;
   assign out_data  = mem[head];
   assign pop       = out_valid && out_ready;
   // words owned after this edge: buffered plus the one returning, minus the one leaving
   assign level     = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
   assign rd_inc    = !rd_rst && !flush && !rd_empty && level < 3'd2;
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         occ      <= '0;
         inflight <= 1'b0;
         head     <= 1'b0;
         tail     <= 1'b0;
         mem      <= '{default: '0};
      end else if (flush) begin
         occ      <= '0;
         inflight <= 1'b0;
         head     <= 1'b0;
         tail     <= 1'b0;
      end else begin
         inflight <= rd_inc;
         occ      <= level[1:0];
         if (inflight) begin
            mem[tail] <= rd_data;
            tail      <= ~tail;
         end
         if (pop) head <= ~head;
      end
   end
`ifdef FIFO_DRAIN_CNT_EN
   always_ff @(posedge rd_clk) begin
      if (rd_rst) rd_count <= '0;
      else if (pop) rd_count <= rd_count + CNT_SIZE'(1);
   end
`else
   assign rd_count = '0;
`endif
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: directed and random drain traffic against a queue-based model of issued words.
module tb_fifo_drain_ctrl;
   logic        rd_clk = 1'b0;
   logic        rd_rst, rd_empty, rd_inc, flush, out_valid, out_ready;
   logic [7:0]  rd_data, out_data;
   logic [15:0] rd_count;

   typedef struct {
      logic [7:0] d;
      int         t;
   } ent_t;

   ent_t       exp_q[$];
   logic [7:0] fifo_q[$];
   int n_chk = 0, n_err = 0, cyc = 0, cnt = 0, inc_n = 0, pop_n = 0;
   logic [7:0] last_pop = '0;
   logic       prev_rst = 1'b1;

   fifo_drain_ctrl #(.DATA_SIZE(8), .CNT_SIZE(16)) dut (
      .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_empty(rd_empty), .rd_data(rd_data),
      .rd_inc(rd_inc), .flush(flush), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .rd_count(rd_count)
   );

   always #5 rd_clk = ~rd_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic load(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(first + 8'(i));
      rd_empty = fifo_q.size() == 0;
   endtask

   // One clock: check outputs at the falling edge, then advance the FIFO and the model.
   task automatic cycle();
      logic s_inc, s_valid, s_rdy, s_fl, s_rst, s_emp, e_valid, do_pop;
      logic [7:0] s_dat, w;
      int lvl;
      @(negedge rd_clk);
      s_inc = rd_inc; s_valid = out_valid; s_rdy = out_ready; s_fl = flush;
      s_rst = rd_rst; s_emp = rd_empty; s_dat = out_data;
      e_valid = exp_q.size() > 0 && exp_q[0].t <= cyc - 2;
      do_pop  = e_valid && s_rdy;
      if (cyc > 0) begin
         chk("out_valid", s_valid, e_valid);
         if (e_valid) chk("out_data", s_dat, exp_q[0].d);
         if (prev_rst) chk("rst_data", s_dat, 0);
         lvl = exp_q.size() - (do_pop ? 1 : 0);
         chk("rd_inc", s_inc, !s_rst && !s_fl && !s_emp && lvl < 2);
         chk("underflow", s_inc && s_emp, 0);
`ifdef FIFO_DRAIN_CNT_EN
         chk("rd_count", rd_count, cnt & 16'hFFFF);
`else
         chk("rd_count", rd_count, 0);
`endif
      end
      @(posedge rd_clk);
      #1;
      w = 8'($urandom);
      if (s_inc && fifo_q.size() > 0) w = fifo_q.pop_front();
      rd_data = s_inc ? w : 8'($urandom);
      rd_empty = fifo_q.size() == 0;
      if (s_inc) inc_n++;
      if (s_rst) begin
         exp_q.delete();
         cnt = 0;
      end else begin
         if (do_pop) begin
            cnt++;
            pop_n++;
            last_pop = exp_q[0].d;
            void'(exp_q.pop_front());
         end
         if (s_fl) exp_q.delete();
         else if (s_inc) exp_q.push_back('{d: w, t: cyc});
      end
      prev_rst = s_rst;
      cyc++;
   endtask

   initial begin
      rd_rst = 1'b1; flush = 1'b0; out_ready = 1'b0; rd_empty = 1'b1; rd_data = '0;
      repeat (3) cycle();
      rd_rst = 1'b0;
      repeat (3) cycle();
      // single word with a late consumer
      inc_n = 0; pop_n = 0;
      load(8'hA5, 1);
      repeat (4) cycle();
      out_ready = 1'b1;
      repeat (3) cycle();
      chk("single_inc", inc_n, 1);
      chk("single_pop", pop_n, 1);
      chk("single_word", last_pop, 8'hA5);
      // sustained streaming
      inc_n = 0; pop_n = 0;
      load(8'h00, 16);
      repeat (20) cycle();
      chk("stream_pop", pop_n, 16);
      chk("stream_last", last_pop, 8'h0F);
      // backpressure mid-burst
      pop_n = 0;
      load(8'h10, 8);
      repeat (3) cycle();
      out_ready = 1'b0; inc_n = 0;
      repeat (5) cycle();
      chk("stall_inc_le2", inc_n <= 2, 1);
      out_ready = 1'b1;
      repeat (12) cycle();
      chk("bp_pop", pop_n, 8);
      chk("bp_last", last_pop, 8'h17);
      // empty boundary
      inc_n = 0; pop_n = 0;
      load(8'h20, 2);
      repeat (6) cycle();
      chk("edge_inc", inc_n, 2);
      chk("edge_pop", pop_n, 2);
      // flush while streaming with a word in flight
      load(8'h30, 16);
      repeat (4) cycle();
      flush = 1'b1; fifo_q.delete(); rd_empty = 1'b1;
      cycle();
      flush = 1'b0;
      cycle();
      pop_n = 0;
      load(8'h55, 1);
      repeat (5) cycle();
      chk("flush_pop", pop_n, 1);
      chk("flush_next", last_pop, 8'h55);
      // reset while streaming
      load(8'h40, 16);
      repeat (4) cycle();
      rd_rst = 1'b1; fifo_q.delete(); rd_empty = 1'b1;
      cycle();
      rd_rst = 1'b0;
      cycle();
      pop_n = 0;
      load(8'h66, 1);
      repeat (5) cycle();
      chk("rst_pop", pop_n, 1);
      chk("rst_next", last_pop, 8'h66);
      // random traffic, backpressure and flushes
      repeat (400) begin
         out_ready = $urandom_range(0, 3) != 0;
         flush = $urandom_range(0, 24) == 0;
         if ($urandom_range(0, 2) == 0) load(8'($urandom), $urandom_range(1, 4));
         cycle();
      end
      flush = 1'b0; out_ready = 1'b1;
      repeat (30) cycle();
      chk("drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
